instr_decode_stage: RTL and testbench
=====================================

INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 Parameters: INSTR_W (default 32) instruction width; REG_AW (default 5) register-address width; XLEN (default 32) extended-immediate width; ZEXT_LOGIC (default 1) zero-extend immediates of andi/ori/xori.
REQ-002 Ports: clk  in  1  single clock, all state on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 in_valid  in  1  upstream instruction valid; in_instr  in  INSTR_W  fetched word.
REQ-005 in_ready  out  1  stage can accept a word this cycle.
REQ-006 flush  in  1  discard all held and incoming words this cycle.
REQ-007 out_valid  out  1; out_ready  in  1  downstream handshake.
REQ-008 out_opcode 6, out_rs REG_AW, out_rt REG_AW, out_rd REG_AW, out_shamt 5, out_funct 6, out_target 26, out_imm XLEN, out_fmt 2 (R/I/J/ILLEGAL), out_wr_zero 1 (destination is register 0), all outputs.
REQ-009 dec_count  out  32  count of words delivered downstream.

Function
REQ-010 Transfer in occurs when in_valid && in_ready; transfer out when out_valid && out_ready.
REQ-011 Stage holds two entries: one output register plus one skid register; latency in->out is one cycle.
REQ-012 in_ready is registered: high exactly when the skid register is empty.
REQ-013 Fields: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm16=[15:0], target=[25:0]; register fields zero-padded to REG_AW.
REQ-014 out_fmt: R when opcode 0x00; J when opcode 0x02 or 0x03; I for opcodes in package legal list; ILLEGAL otherwise.
REQ-015 out_imm: zero-extended imm16 for opcodes 0x0C/0x0D/0x0E when ZEXT_LOGIC=1, else sign-extended to XLEN; J-format out_imm = target zero-extended.
REQ-016 out_wr_zero: R uses rd==0, I uses rt==0, J 0x03 writes reg 31 so 0, J 0x02 and ILLEGAL 1.
REQ-017 Output register empty or draining: incoming word loads it directly; output stalled: incoming word goes to skid.
REQ-018 When output drains and skid is full, skid moves to output next edge, skid empties, in_ready rises.
REQ-019 Outputs other than out_valid hold stable while out_valid && !out_ready.
REQ-020 flush: both entries invalidated at next edge, concurrent input word dropped, in_ready=1 next cycle; flush dominates a simultaneous transfer, dec_count not incremented for it.
REQ-021 dec_count increments by one per output transfer, wraps 0xFFFFFFFF->0.
REQ-022 Word accepted in same cycle as output drain with empty skid passes to output with no bubble; sustained throughput one word/cycle.

Reset
REQ-023 On rst assertion, immediately: out_valid=0, skid empty, in_ready=1, dec_count=0, all decoded field outputs 0, out_fmt=R.
REQ-024 Reset mid-stall discards both held words; none reappear after release.
REQ-025 First transfer accepted on the first clk edge after rst deasserts.

Structure
REQ-026 Package instr_decode_pkg holds: format enum (FMT_R, FMT_I, FMT_J, FMT_ILLEGAL), opcode constants, legal I-opcode list, field bit-position constants.
REQ-027 One combinational sub-module instr_field_decode (word -> fields, fmt, imm, wr_zero), instantiated twice: input path and skid path, or once ahead of both registers.

Verification
REQ-028 0x012A4020 with out_ready=1 -> next cycle fmt R, rs 9, rt 10, rd 8, shamt 0, funct 0x20, wr_zero 0, dec_count 1.
REQ-029 0x2128FFFF -> fmt I, opcode 0x08, rs 9, rt 8, imm 0xFFFFFFFF; 0x3128FFFF -> imm 0x0000FFFF.
REQ-030 0x08000010 -> fmt J, target 0x10, wr_zero 1; 0xFC000000 -> fmt ILLEGAL.
REQ-031 out_ready=0, three back-to-back words -> first held, second in skid, in_ready=0, third not accepted; release -> in-order delivery, none lost or duplicated.
REQ-032 flush with both entries full and in_valid=1 -> out_valid=0, in_ready=1 next cycle, dec_count unchanged.
REQ-033 rst pulsed asynchronously mid-stall -> outputs zero without clock edge; 1000 random valid/ready cycles match scoreboard, dec_count equals delivered count.

Source files
------------

// File: rtl/instr_decode_pkg.sv
// rtl/instr_decode_pkg.sv - shared formats, opcodes and field positions for the decode stage
package instr_decode_pkg;

    typedef enum logic [1:0] {
        FMT_R       = 2'd0,
        FMT_I       = 2'd1,
        FMT_J       = 2'd2,
        FMT_ILLEGAL = 2'd3
    } fmt_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;

    localparam int OPC_LSB   = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_LSB = 0;

    localparam int N_LEGAL_I = 20;
    localparam logic [5:0] LEGAL_I_OPS [N_LEGAL_I] = '{
        6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
        6'h0E, 6'h0F, 6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B
    };

    function automatic logic is_legal_i(input logic [5:0] op);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_LEGAL_I; i++) begin
            if (LEGAL_I_OPS[i] == op) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// rtl/instr_field_decode.sv - combinational split of one instruction word into decoded fields
module instr_field_decode
    import instr_decode_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int REG_AW     = 5,
    parameter int XLEN       = 32,
    parameter int ZEXT_LOGIC = 1
) (
    input  logic [INSTR_W-1:0] i_instr,
    output logic [5:0]         o_opcode,
    output logic [REG_AW-1:0]  o_rs,
    output logic [REG_AW-1:0]  o_rt,
    output logic [REG_AW-1:0]  o_rd,
    output logic [4:0]         o_shamt,
    output logic [5:0]         o_funct,
    output logic [25:0]        o_target,
    output logic [XLEN-1:0]    o_imm,
    output fmt_e               o_fmt,
    output logic               o_wr_zero
);

    logic [15:0] w_imm16;
    logic        w_zext;

    always_comb begin
        o_opcode = i_instr[OPC_LSB +: 6];
        o_rs     = REG_AW'(i_instr[RS_LSB +: 5]);
        o_rt     = REG_AW'(i_instr[RT_LSB +: 5]);
        o_rd     = REG_AW'(i_instr[RD_LSB +: 5]);
        o_shamt  = i_instr[SHAMT_LSB +: 5];
        o_funct  = i_instr[FUNCT_LSB +: 6];
        o_target = i_instr[25:0];
        w_imm16  = i_instr[15:0];

        if (o_opcode == OP_RTYPE)                             o_fmt = FMT_R;
        else if (o_opcode == OP_J || o_opcode == OP_JAL)      o_fmt = FMT_J;
        else if (is_legal_i(o_opcode))                        o_fmt = FMT_I;
        else                                                  o_fmt = FMT_ILLEGAL;

        // Logical immediates are unsigned operands; everything else sign-extends.
        w_zext = (ZEXT_LOGIC != 0) &&
                 (o_opcode == OP_ANDI || o_opcode == OP_ORI || o_opcode == OP_XORI);
        if (o_fmt == FMT_J)  o_imm = XLEN'(o_target);
        else if (w_zext)     o_imm = XLEN'(w_imm16);
        else                 o_imm = XLEN'($signed(w_imm16));

        case (o_fmt)
            FMT_R:   o_wr_zero = (i_instr[RD_LSB +: 5] == 5'd0);
            FMT_I:   o_wr_zero = (i_instr[RT_LSB +: 5] == 5'd0);
            FMT_J:   o_wr_zero = (o_opcode != OP_JAL);
            default: o_wr_zero = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_decode_stage.sv
// rtl/instr_decode_stage.sv - decode pipeline stage with output register and one-entry skid buffer
module instr_decode_stage
    import instr_decode_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int REG_AW     = 5,
    parameter int XLEN       = 32,
    parameter int ZEXT_LOGIC = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    output logic               in_ready,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [5:0]         out_opcode,
    output logic [REG_AW-1:0]  out_rs,
    output logic [REG_AW-1:0]  out_rt,
    output logic [REG_AW-1:0]  out_rd,
    output logic [4:0]         out_shamt,
    output logic [5:0]         out_funct,
    output logic [25:0]        out_target,
    output logic [XLEN-1:0]    out_imm,
    output logic [1:0]         out_fmt,
    output logic               out_wr_zero,
    output logic [31:0]        dec_count
);

    logic               r_out_valid;
    logic               r_skid_valid;
    logic [INSTR_W-1:0] r_skid_instr;
    logic [5:0]         r_opcode;
    logic [REG_AW-1:0]  r_rs, r_rt, r_rd;
    logic [4:0]         r_shamt;
    logic [5:0]         r_funct;
    logic [25:0]        r_target;
    logic [XLEN-1:0]    r_imm;
    fmt_e               r_fmt;
    logic               r_wr_zero;
    logic [31:0]        r_dec_count;

    logic               w_in_fire, w_out_fire, w_out_free;
    logic [INSTR_W-1:0] w_src;
    logic [5:0]         w_opcode;
    logic [REG_AW-1:0]  w_rs, w_rt, w_rd;
    logic [4:0]         w_shamt;
    logic [5:0]         w_funct;
    logic [25:0]        w_target;
    logic [XLEN-1:0]    w_imm;
    fmt_e               w_fmt;
    logic               w_wr_zero;

    assign in_ready   = ~r_skid_valid;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;
    assign w_out_free = ~r_out_valid || out_ready;

    // The skid word always has priority: while it is held, in_ready is low.
    assign w_src = r_skid_valid ? r_skid_instr : in_instr;

    instr_field_decode #(
        .INSTR_W(INSTR_W), .REG_AW(REG_AW), .XLEN(XLEN), .ZEXT_LOGIC(ZEXT_LOGIC)
    ) u_dec (
        .i_instr  (w_src),
        .o_opcode (w_opcode),
        .o_rs     (w_rs),
        .o_rt     (w_rt),
        .o_rd     (w_rd),
        .o_shamt  (w_shamt),
        .o_funct  (w_funct),
        .o_target (w_target),
        .o_imm    (w_imm),
        .o_fmt    (w_fmt),
        .o_wr_zero(w_wr_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_instr <= '0;
            r_opcode     <= '0;
            r_rs         <= '0;
            r_rt         <= '0;
            r_rd         <= '0;
            r_shamt      <= '0;
            r_funct      <= '0;
            r_target     <= '0;
            r_imm        <= '0;
            r_fmt        <= FMT_R;
            r_wr_zero    <= 1'b0;
            r_dec_count  <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else begin
            if (w_out_fire) r_dec_count <= r_dec_count + 32'd1;
            if (w_out_free) begin
                r_out_valid <= r_skid_valid || w_in_fire;
                if (r_skid_valid || w_in_fire) begin
                    r_opcode  <= w_opcode;
                    r_rs      <= w_rs;
                    r_rt      <= w_rt;
                    r_rd      <= w_rd;
                    r_shamt   <= w_shamt;
                    r_funct   <= w_funct;
                    r_target  <= w_target;
                    r_imm     <= w_imm;
                    r_fmt     <= w_fmt;
                    r_wr_zero <= w_wr_zero;
                end
                r_skid_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_skid_instr <= in_instr;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_opcode  = r_opcode;
    assign out_rs      = r_rs;
    assign out_rt      = r_rt;
    assign out_rd      = r_rd;
    assign out_shamt   = r_shamt;
    assign out_funct   = r_funct;
    assign out_target  = r_target;
    assign out_imm     = r_imm;
    assign out_fmt     = r_fmt;
    assign out_wr_zero = r_wr_zero;
    assign dec_count   = r_dec_count;

endmodule

// File: tb/tb_instr_decode_stage.sv
// tb/tb_instr_decode_stage.sv - randomized bench for instr_decode_stage against a queue model
module tb_instr_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rs, out_rt, out_rd;
    logic [4:0]  out_shamt;
    logic [5:0]  out_funct;
    logic [25:0] out_target;
    logic [31:0] out_imm;
    logic [1:0]  out_fmt;
    logic        out_wr_zero;
    logic [31:0] dec_count;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_q[$];
    logic [31:0] delivered = 0;

    always #5 clk = ~clk;

    instr_decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd), .out_shamt(out_shamt),
        .out_funct(out_funct), .out_target(out_target), .out_imm(out_imm), .out_fmt(out_fmt),
        .out_wr_zero(out_wr_zero), .dec_count(dec_count)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference decode straight from the field and format rules.
    task automatic ref_decode(input logic [31:0] w, output int fmt, output logic [31:0] imm,
                              output logic wz);
        int opc, rt, rd, imm16;
        int legal[20] = '{'h04, 'h05, 'h06, 'h07, 'h08, 'h09, 'h0A, 'h0B, 'h0C, 'h0D,
                          'h0E, 'h0F, 'h20, 'h21, 'h23, 'h24, 'h25, 'h28, 'h29, 'h2B};
        opc   = int'(w >> 26);
        rt    = int'((w >> 16) % 32);
        rd    = int'((w >> 11) % 32);
        imm16 = int'(w % 65536);
        fmt   = 3;
        if (opc == 0) fmt = 0;
        else if (opc == 2 || opc == 3) fmt = 2;
        else foreach (legal[i]) if (legal[i] == opc) fmt = 1;
        if (fmt == 2)                    imm = w % (1 << 26);
        else if (opc >= 'h0C && opc <= 'h0E) imm = imm16;
        else if (imm16 >= 32768)         imm = 32'(imm16) + 32'hFFFF0000;
        else                             imm = imm16;
        case (fmt)
            0:       wz = (rd == 0);
            1:       wz = (rt == 0);
            2:       wz = (opc == 2);
            default: wz = 1'b1;
        endcase
    endtask

    task automatic check_state();
        int          fmt;
        logic [31:0] imm;
        logic        wz;
        logic [31:0] w;
        check_eq("out_valid", out_valid, model_q.size() > 0);
        check_eq("in_ready", in_ready, model_q.size() < 2);
        check_eq("dec_count", dec_count, delivered);
        if (model_q.size() > 0) begin
            w = model_q[0];
            ref_decode(w, fmt, imm, wz);
            check_eq("opcode", out_opcode, w >> 26);
            check_eq("rs", out_rs, (w >> 21) % 32);
            check_eq("rt", out_rt, (w >> 16) % 32);
            check_eq("rd", out_rd, (w >> 11) % 32);
            check_eq("shamt", out_shamt, (w >> 6) % 32);
            check_eq("funct", out_funct, w % 64);
            check_eq("target", out_target, w % (1 << 26));
            check_eq("imm", out_imm, imm);
            check_eq("fmt", out_fmt, fmt);
            check_eq("wr_zero", out_wr_zero, wz);
        end
    endtask

    task automatic step(input logic iv, input logic [31:0] w, input logic ordy, input logic fl);
        logic acc, drain;
        @(negedge clk);
        check_state();
        in_valid  = iv;
        in_instr  = w;
        out_ready = ordy;
        flush     = fl;
        acc   = iv && (model_q.size() < 2);
        drain = ordy && (model_q.size() > 0);
        if (fl) begin
            model_q.delete();
        end else begin
            if (drain) begin
                void'(model_q.pop_front());
                delivered++;
            end
            if (acc) model_q.push_back(w);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, out_valid, 0);
        check_eq({tag, "_ready"}, in_ready, 1);
        check_eq({tag, "_count"}, dec_count, 0);
        check_eq({tag, "_fields"}, {out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct}, 0);
        check_eq({tag, "_tgt_imm"}, {out_target, out_imm, out_wr_zero}, 0);
        check_eq({tag, "_fmt"}, out_fmt, 0);
    endtask

    initial begin
        logic [5:0]  ops[8] = '{6'h00, 6'h02, 6'h03, 6'h08, 6'h0C, 6'h0E, 6'h23, 6'h3F};
        logic [31:0] w;
        rst = 1'b1; in_valid = 0; in_instr = 0; out_ready = 0; flush = 0;
        #1 check_reset_outputs("rst_init");
        @(negedge clk) rst = 1'b0;

        step(1, 32'h012A4020, 1, 0);
        step(0, 0, 1, 0);
        check_eq("r_fmt", out_fmt, 0);
        check_eq("r_regs", {out_rs, out_rt, out_rd}, {5'd9, 5'd10, 5'd8});
        check_eq("r_shamt_funct", {out_shamt, out_funct}, {5'd0, 6'h20});
        check_eq("r_wr_zero", out_wr_zero, 0);
        step(0, 0, 1, 0);
        check_eq("r_count", dec_count, 1);

        step(1, 32'h2128FFFF, 1, 0);
        step(1, 32'h3128FFFF, 1, 0);
        check_eq("i_fmt", out_fmt, 1);
        check_eq("i_opc_rs_rt", {out_opcode, out_rs, out_rt}, {6'h08, 5'd9, 5'd8});
        check_eq("i_imm_sext", out_imm, 32'hFFFFFFFF);
        step(1, 32'h08000010, 1, 0);
        check_eq("i_imm_zext", out_imm, 32'h0000FFFF);
        step(1, 32'hFC000000, 1, 0);
        check_eq("j_fmt", out_fmt, 2);
        check_eq("j_target", out_target, 26'h10);
        check_eq("j_wr_zero", out_wr_zero, 1);
        step(0, 0, 1, 0);
        check_eq("ill_fmt", out_fmt, 3);
        step(0, 0, 1, 0);

        step(1, 32'h20010001, 0, 0);
        step(1, 32'h20020002, 0, 0);
        step(1, 32'h20030003, 0, 0);
        check_eq("stall_in_ready", in_ready, 0);
        check_eq("stall_head", out_imm, 1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);

        step(1, 32'h20040004, 0, 0);
        step(1, 32'h20050005, 0, 0);
        step(1, 32'h20060006, 1, 1);
        step(0, 0, 1, 0);
        check_eq("flush_valid", out_valid, 0);
        check_eq("flush_ready", in_ready, 1);
        check_eq("flush_count", dec_count, delivered);

        step(1, 32'h20070007, 0, 0);
        step(1, 32'h20080008, 0, 0);
        step(0, 0, 0, 0);
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_async");
        in_valid = 0;
        @(negedge clk);
        rst = 1'b0;
        model_q.delete();
        delivered = 0;
        step(1, 32'h20090009, 1, 0);
        step(0, 0, 1, 0);
        check_eq("post_rst_first", out_imm, 9);

        for (int c = 0; c < 1000; c++) begin
            w = $urandom;
            if ($urandom_range(0, 1) == 1) w[31:26] = ops[$urandom_range(0, 7)];
            step($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 49) == 0);
        end
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        @(negedge clk);
        check_state();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
